// File: rtl/srv32_dmem_pkg.sv
// Shared types and helpers for the data-memory to SRAM bridge.
//
// Contents:
//   WORD_LSB    - lowest byte-address bit that selects a 32-bit word
//   WADDR_W     - width of a full word address (byte address minus WORD_LSB bits)
//   wb_entry_t  - one posted-store record {word addr, data, byte strobes}
//   sram_cmd_t  - the single SRAM access chosen in a cycle
//   word_addr() - byte address -> word address, keeping only the low
//                 'awidth' word bits so higher bits alias onto the SRAM
package srv32_dmem_pkg;

  localparam int WORD_LSB = 2;
  localparam int WADDR_W  = 32 - WORD_LSB;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [31:0]        data;
    logic [3:0]         strb;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRAM_IDLE  = 2'd0,
    SRAM_READ  = 2'd1,
    SRAM_WRITE = 2'd2
  } sram_cmd_t;

  // Upper word-address bits are zeroed here so that every address compare
  // downstream already sees the aliased SRAM address.
  function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] byte_addr,
                                                   input int          awidth);
    logic [WADDR_W-1:0] mask;
    mask = (WADDR_W'(1) << awidth) - WADDR_W'(1);
    return WADDR_W'(byte_addr >> WORD_LSB) & mask;
  endfunction

endpackage

// File: rtl/srv32_wbuf.sv
// Posted write buffer: a circular FIFO of store records plus an address
// compare against every occupied slot (used for read-after-write blocking).
//
// Ports:
//   clk, resetb  - clock, asynchronous active-low reset (empties the buffer)
//   push         - enqueue push_entry (ignored when full)
//   push_entry   - store record to enqueue
//   pop          - retire the head entry (ignored when empty)
//   cmp_addr     - word address checked against the buffered entries
//   full, empty  - occupancy flags, derived from registered count
//   head         - oldest buffered entry
//   addr_hit     - cmp_addr matches some occupied slot
module srv32_wbuf
  import srv32_dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               push,
  input  wb_entry_t          push_entry,
  input  logic               pop,
  input  logic [WADDR_W-1:0] cmp_addr,
  output logic               full,
  output logic               empty,
  output wb_entry_t          head,
  output logic               addr_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

  // A slot is occupied when its distance from the head is below count;
  // only occupied slots may raise a hit.
  always_comb begin
    logic [PTR_W-1:0] offset;
    addr_hit = 1'b0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(offset) < count) && (entries[i].addr == cmp_addr)) addr_hit = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Bridge from the core's data-memory channels to one single-port
// synchronous SRAM. Stores are posted into a small write buffer; loads
// take the SRAM port first unless the buffer is full, and a load whose
// word is still buffered (or being buffered this cycle) is held off.
// Load data comes back exactly one cycle after acceptance.
//
// Ports:
//   clk, resetb                  - clock, asynchronous active-low reset
//   dmem_wready/waddr/wdata/wstrb - store request from the core
//   dmem_wvalid                  - store accepted (buffer not full)
//   dmem_rready/raddr            - load request from the core
//   dmem_rvalid                  - load accepted this cycle
//   dmem_rresp/rdata             - load response, one cycle after acceptance
//   sram_ce/we/addr/wdata/wstrb  - SRAM access for this cycle
//   sram_rdata                   - SRAM read data, valid the cycle after a read
//   wb_empty                     - no posted stores outstanding
module dmem_sram_bridge
  import srv32_dmem_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int AWIDTH   = 14
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              dmem_wready,
  output logic              dmem_wvalid,
  input  logic [31:0]       dmem_waddr,
  input  logic [31:0]       dmem_wdata,
  input  logic [3:0]        dmem_wstrb,
  input  logic              dmem_rready,
  output logic              dmem_rvalid,
  input  logic [31:0]       dmem_raddr,
  output logic              dmem_rresp,
  output logic [31:0]       dmem_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_wstrb,
  input  logic [31:0]       sram_rdata,
  output logic              wb_empty
);

  logic [WADDR_W-1:0] load_addr;
  logic [WADDR_W-1:0] store_addr;
  wb_entry_t          store_entry;
  wb_entry_t          head;
  logic               full;
  logic               empty;
  logic               buf_hit;
  logic               store_push;
  logic               hazard;
  logic               load_accept;
  logic               drain;
  logic               rd_pend;
  sram_cmd_t          sram_cmd;

  assign load_addr   = word_addr(dmem_raddr, AWIDTH);
  assign store_addr  = word_addr(dmem_waddr, AWIDTH);
  assign store_entry = '{addr: store_addr, data: dmem_wdata, strb: dmem_wstrb};

  // Acceptance never looks at a same-cycle drain: a full buffer always
  // refuses the store, even while it is emptying a slot.
  assign dmem_wvalid = !full;
  assign store_push  = dmem_wready && dmem_wvalid;

  // The store being enqueued right now counts as buffered for the load.
  assign hazard      = buf_hit || (store_push && (store_addr == load_addr));

  // A full buffer blocks loads so the drain is guaranteed the port.
  assign load_accept = dmem_rready && !hazard && !full;
  assign dmem_rvalid = load_accept;

  srv32_wbuf #(
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .resetb     (resetb),
    .push       (store_push),
    .push_entry (store_entry),
    .pop        (drain),
    .cmp_addr   (load_addr),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .addr_hit   (buf_hit)
  );

  // One SRAM access per cycle: accepted load first, then the buffer head.
  always_comb begin
    sram_cmd = SRAM_IDLE;
    if (load_accept) sram_cmd = SRAM_READ;
    else if (!empty) sram_cmd = SRAM_WRITE;
  end

  assign drain = (sram_cmd == SRAM_WRITE);

  // Strobes stay zero on reads so a stray write enable can never land.
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wstrb = '0;
    case (sram_cmd)
      SRAM_READ: begin
        sram_ce   = 1'b1;
        sram_addr = AWIDTH'(load_addr);
      end
      SRAM_WRITE: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = AWIDTH'(head.addr);
        sram_wdata = head.data;
        sram_wstrb = head.strb;
      end
      default: ;
    endcase
  end

  // The SRAM presents read data the cycle after the access, so the
  // response only needs a one-cycle flag alongside it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) rd_pend <= 1'b0;
    else         rd_pend <= load_accept;
  end

  assign dmem_rresp = rd_pend;
  assign dmem_rdata = sram_rdata;
  assign wb_empty   = empty;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge. A behavioural SRAM sits on the
// SRAM port; a cycle model of the buffer predicts handshakes and SRAM
// commands, a reference memory tracks drained stores, and a scoreboard
// queue holds expected load data until the response arrives.
module tb_dmem_sram_bridge;

  localparam int WB = 4;
  localparam int AW = 14;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } st_t;

  logic          clk = 1'b0;
  logic          resetb;
  logic          dmem_wready, dmem_wvalid;
  logic [31:0]   dmem_waddr, dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_rready, dmem_rvalid;
  logic [31:0]   dmem_raddr;
  logic          dmem_rresp;
  logic [31:0]   dmem_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wstrb;
  logic [31:0]   sram_rdata;
  logic          wb_empty;

  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [31:0]   preload_data = '0;

  logic [31:0]   sram_mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem  [0:(1<<AW)-1];
  st_t           mq [$];
  logic [31:0]   sb [$];
  logic          exp_pend = 1'b0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.WB_DEPTH(WB), .AWIDTH(AW)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .dmem_wready (dmem_wready),
    .dmem_wvalid (dmem_wvalid),
    .dmem_waddr  (dmem_waddr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_rready (dmem_rready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_raddr  (dmem_raddr),
    .dmem_rresp  (dmem_rresp),
    .dmem_rdata  (dmem_rdata),
    .sram_ce     (sram_ce),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wstrb  (sram_wstrb),
    .sram_rdata  (sram_rdata),
    .wb_empty    (wb_empty)
  );

  // Behavioural single-port SRAM with a backdoor preload port.
  always @(posedge clk) begin
    if (preload_en) begin
      sram_mem[preload_addr] <= preload_data;
    end else if (sram_ce && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_wstrb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end else if (sram_ce) begin
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  function automatic logic [AW-1:0] tb_word(input logic [31:0] a);
    return AW'(a >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    preload_en   = 1'b1;
    preload_addr = a;
    preload_data = d;
    ref_mem[a]   = d;
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  // One cycle: drive requests at posedge+1, check at posedge+4, advance the model.
  task automatic applyStimulus(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic rd, input logic [31:0] raddr);
    logic          full_e, enq_e, haz_e, racc_e, drain_e;
    logic [AW-1:0] wa, ra;
    logic [31:0]   exp_data;
    st_t           hd;
    dmem_wready = wr;
    dmem_waddr  = waddr;
    dmem_wdata  = wdata;
    dmem_wstrb  = wstrb;
    dmem_rready = rd;
    dmem_raddr  = raddr;
    #3;
    checkOutput("rresp", 32'(dmem_rresp), 32'(exp_pend));
    if (exp_pend) begin
      exp_data = sb.pop_front();
      if (dmem_rresp === 1'b1) checkOutput("rdata", dmem_rdata, exp_data);
    end
    wa      = tb_word(waddr);
    ra      = tb_word(raddr);
    full_e  = (mq.size() == WB);
    enq_e   = wr && !full_e;
    haz_e   = enq_e && (wa == ra);
    foreach (mq[i]) if (mq[i].addr == ra) haz_e = 1'b1;
    racc_e  = rd && !haz_e && !full_e;
    drain_e = !racc_e && (mq.size() > 0);
    checkOutput("wvalid", 32'(dmem_wvalid), 32'(!full_e));
    checkOutput("rvalid", 32'(dmem_rvalid), 32'(racc_e));
    checkOutput("sram_ce", 32'(sram_ce), 32'(racc_e || drain_e));
    checkOutput("wb_empty", 32'(wb_empty), 32'(mq.size() == 0));
    if (racc_e || drain_e) checkOutput("sram_we", 32'(sram_we), 32'(drain_e));
    if (racc_e) checkOutput("sram_addr_rd", 32'(sram_addr), 32'(ra));
    if (drain_e) begin
      hd = mq.pop_front();
      checkOutput("sram_addr_wr", 32'(sram_addr), 32'(hd.addr));
      checkOutput("sram_wdata", sram_wdata, hd.data);
      checkOutput("sram_wstrb", 32'(sram_wstrb), 32'(hd.strb));
      ref_mem[hd.addr] = merge(ref_mem[hd.addr], hd.data, hd.strb);
    end else begin
      checkOutput("sram_wstrb_idle", 32'(sram_wstrb), 32'd0);
    end
    if (enq_e) mq.push_back('{addr: wa, data: wdata, strb: wstrb});
    if (racc_e) sb.push_back(ref_mem[ra]);
    exp_pend = racc_e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    resetb      = 1'b0;
    dmem_wready = 1'b0;
    dmem_waddr  = '0;
    dmem_wdata  = '0;
    dmem_wstrb  = '0;
    dmem_rready = 1'b0;
    dmem_raddr  = '0;
    #1;
    checkOutput("reset_wb_empty", 32'(wb_empty), 32'd1);
    checkOutput("reset_rresp", 32'(dmem_rresp), 32'd0);
    checkOutput("reset_sram_ce", 32'(sram_ce), 32'd0);
    preload(14'h010, 32'hDEAD_BEEF);
    preload(14'h080, 32'h0200_0200);
    preload(14'h100, 32'h0400_0400);
    preload(14'h020, 32'h1111_1111);
    preload(14'h040, 32'h2222_2222);
    preload(14'h140, 32'h5000_0000);
    preload(14'h141, 32'h5040_0000);
    preload(14'h142, 32'h5080_0000);
    resetb = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] load-only and address aliasing");
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0040);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0001_0043);
    idle(1);

    $display("[TB] posted store then drain");
    applyStimulus(1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    idle(2);

    $display("[TB] RAW hazard");
    applyStimulus(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h0000_0080);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0080);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0080);
    idle(1);

    $display("[TB] zero-strobe store");
    applyStimulus(1'b1, 32'h0000_0600, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
    idle(2);

    $display("[TB] full buffer and simultaneous enqueue/drain");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h0000_0300 + 32'(4*i), 32'hC000_0000 + 32'(i), 4'hF, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0310, 32'hC000_0004, 4'hF, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0310, 32'hC000_0004, 4'hF, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0314, 32'hC000_0005, 4'hF, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0314, 32'hC000_0005, 4'hF, 1'b0, 32'h0);
    checkOutput("count_three_not_empty", 32'(wb_empty), 32'd0);
    checkOutput("count_three_wvalid", 32'(dmem_wvalid), 32'd1);
    idle(5);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h0000_0500, 32'hBAD0_0000, 4'hF, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0504, 32'hBAD0_0001, 4'hF, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0508, 32'hBAD0_0002, 4'hF, 1'b1, 32'h0000_0400);
    dmem_wready = 1'b0;
    dmem_rready = 1'b0;
    resetb      = 1'b0;
    #1;
    checkOutput("async_wb_empty", 32'(wb_empty), 32'd1);
    checkOutput("async_rresp", 32'(dmem_rresp), 32'd0);
    mq.delete();
    sb.delete();
    exp_pend = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    idle(3);

    $display("[TB] final memory contents");
    checkOutput("mem_0x80", sram_mem[14'h020], ref_mem[14'h020]);
    checkOutput("mem_0x100", sram_mem[14'h040], ref_mem[14'h040]);
    for (int i = 0; i < 6; i++)
      checkOutput("mem_0x300", sram_mem[14'h0C0 + AW'(i)], ref_mem[14'h0C0 + AW'(i)]);
    for (int i = 0; i < 3; i++)
      checkOutput("mem_stale", sram_mem[14'h140 + AW'(i)], ref_mem[14'h140 + AW'(i)]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
